// File: rtl/exec_ctrl.sv
// Execution controller: debounced run/step/halt buttons drive a small FSM that gates the
// core's pc/regfile/memory write enables, with PC breakpoint, HALT stop and an instruction counter.
module exec_ctrl #(
    parameter int PC_W      = 9,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_halt,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             op_halt,
    input  logic             pc_we_in,
    input  logic             reg_we_in,
    input  logic             mem_we_in,
    output logic             pc_we,
    output logic             reg_we,
    output logic             mem_we,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] icnt
);

    localparam int DB_W = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    // Button lanes: bit 0 run, bit 1 step, bit 2 halt.
    logic [2:0]            btn_raw;
    logic [2:0]            sync1_q, sync1_d;
    logic [2:0]            sync2_q, sync2_d;
    logic [2:0]            db_q, db_d;
    logic [2:0]            db_prev_q, db_prev_d;
    logic [2:0]            pulse_q, pulse_d;
    logic [2:0][DB_W-1:0]  cnt_q, cnt_d;

    state_t                state_q, state_d;
    logic                  resume_q, resume_d;
    logic                  bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]      icnt_q, icnt_d;

    logic                  act_run, act_step, act_halt;
    logic                  blk, en;

    assign btn_raw = {btn_halt, btn_step, btn_run};

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        db_prev_d = db_q;
        pulse_d   = db_q & ~db_prev_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            pulse_q   <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        act_halt = pulse_q[2];
        act_step = pulse_q[1] & ~pulse_q[2];
        act_run  = pulse_q[0] & ~pulse_q[1] & ~pulse_q[2];

        // resume lets the first instruction after a (re)start sit on the breakpoint address.
        blk = op_halt | ((state_q == S_RUN) & bp_en & (pc == bp_addr) & ~resume_q);
        en  = ((state_q == S_RUN) | (state_q == S_STEP)) & ~blk;

        state_d  = state_q;
        resume_d = resume_q & ~en;

        case (state_q)
            S_IDLE, S_BREAK: begin
                if (act_halt) begin
                    state_d = S_IDLE;
                end else if (act_step) begin
                    state_d = S_STEP;
                end else if (act_run) begin
                    state_d  = S_RUN;
                    resume_d = 1'b1;
                end
            end
            S_RUN: begin
                if (act_halt) begin
                    state_d = S_IDLE;
                end else if (blk) begin
                    state_d = S_BREAK;
                end
            end
            S_STEP: begin
                // A halt press during the step cycle is absorbed: the step still completes.
                state_d = op_halt ? S_BREAK : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        bp_hit_d = (state_d == S_BREAK);
        icnt_d   = (en && (icnt_q != '1)) ? icnt_q + 1'b1 : icnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            resume_q <= 1'b0;
            bp_hit_q <= 1'b0;
            icnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            bp_hit_q <= bp_hit_d;
            icnt_q   <= icnt_d;
        end
    end

    assign pc_we  = pc_we_in  & en;
    assign reg_we = reg_we_in & en;
    assign mem_we = mem_we_in & en;
    assign state  = state_q;
    assign bp_hit = bp_hit_q;
    assign icnt   = icnt_q;

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execution controller for the single-cycle core. It sits between the decoder's write enables and the pc, regfile and memory, and gates `pc_we`, `reg_we` and `mem_we` so the core can be run, halted, single-stepped, or stopped on a PC breakpoint or halt instruction from the board buttons. It also keeps a saturating executed-instruction counter for the io block to display.

## Interface
Parameters:
- `PC_W`, 9, PC width; matches pc/imem.
- `DB_CYCLES`, 16, number of consecutive stable clk cycles needed to accept a button level change (≥2).
- `CNT_W`, 26, executed-instruction counter width; matches the datapath word.

Ports:
- `clk` input 1: divided system clock, the same one that drives the core. The design has one clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_run`, `btn_step`, `btn_halt` input 1 each: raw, unsynchronised, active-high buttons.
- `bp_en` input 1: breakpoint enable (switch).
- `bp_addr` input PC_W: breakpoint address.
- `pc` input PC_W: current pc_out.
- `op_halt` input 1: decoder flag meaning the current instruction is HALT.
- `pc_we_in`, `reg_we_in`, `mem_we_in` input 1 each: write enables from the decoder.
- `pc_we`, `reg_we`, `mem_we` output 1 each: gated enables to pc, regfile and memory.
- `state` output 2: 0 IDLE, 1 RUN, 2 STEP, 3 BREAK.
- `bp_hit` output 1: registered; 1 while in BREAK because of a breakpoint or HALT.
- `icnt` output CNT_W: executed-instruction count.

## Operation
Button front end (one copy per button):
- Two-flop synchroniser, then a debouncer. A counter runs while the synchronised level differs from the debounced level and clears whenever they match.
- When the counter reaches DB_CYCLES−1 and the levels still differ, the debounced level flips at the next edge.
- A registered rising-edge detector on the debounced level gives a one-cycle pulse: `p_run`, `p_step` or `p_halt`.
- Only one pulse is acted on per cycle. Priority is halt > step > run.

Enable:
- `en` = (state==RUN or state==STEP) and not `blk`.
- `blk` = `op_halt`, or (state==RUN and `bp_en` and pc==bp_addr and not `resume`).
- Gated outputs are `x_we = x_we_in & en`. They are purely combinational from the registered state and the inputs.

State machine (all transitions on the clk edge):
- IDLE: `p_run` → RUN with `resume`=1. `p_step` → STEP. `p_halt` → stay.
- RUN:
  - `p_halt` → IDLE.
  - Else if `blk` → BREAK.
  - Else stay.
  - `resume` clears after the first cycle with `en`=1.
- STEP: lasts exactly one cycle.
  - If `blk` is caused by `op_halt` → BREAK.
  - Otherwise one instruction executes, including at a breakpoint address, then → IDLE.
  - A `p_halt` in that cycle still lets the step complete, then → IDLE.
- BREAK: `p_run` → RUN with `resume`=1, so the first instruction is not re-blocked by the breakpoint. `p_step` → STEP. `p_halt` → IDLE.
- While stopped at HALT, `op_halt` keeps `blk` high, so run and step return to BREAK without executing.

Status outputs:
- `bp_hit` = 1 exactly while state==BREAK.
- `icnt` increments by 1 on every edge where `en`=1 and saturates at all-ones (no wrap). Only reset clears it.

## Timing
- Reset values:
  - state=IDLE, `resume`=0, `bp_hit`=0, `icnt`=0.
  - Synchronisers, debounced levels, counters and edge registers are all 0.
  - Therefore `pc_we`=`reg_we`=`mem_we`=0.
- Reset asserted mid-run forces IDLE immediately (asynchronously). Gated enables drop in the same instant.
- Button latency:
  - Raw input changes before edge 0 and then holds.
  - The synchroniser output changes at edge 1.
  - The debounced level changes at edge DB_CYCLES+1.
  - The pulse is high for the cycle after edge DB_CYCLES+2.
  - The state changes at edge DB_CYCLES+3.
- A glitch shorter than DB_CYCLES synchronised cycles produces no pulse.
- A held button produces exactly one pulse.
- Enable timing:
  - In RUN, `en` is high in the same cycle the state is RUN.
  - The first gated instruction executes at edge DB_CYCLES+4 after the run press.
  - A breakpoint blocks the cycle in which `pc` equals `bp_addr`. That instruction does not execute, and pc still equals `bp_addr` in BREAK.
- Throughput: one instruction per clk in RUN. STEP executes at most one instruction per press.

## Test plan
- Reset, then hold all buttons low for 50 cycles → state=0, all gated enables 0, `icnt`=0.
- With DB_CYCLES=4, a btn_run glitch of 3 cycles → no state change. A clean btn_run press → state=1 at edge 7 after the raw rise, `pc_we` follows `pc_we_in`, and `icnt` counts 1 per cycle.
- `bp_en`=1, `bp_addr`=5, run from pc=0 → instructions 0–4 execute, state=3, `bp_hit`=1, pc holds 5, `icnt`=5. Press run → instruction 5 executes and the core continues past it.
- From IDLE, three step presses → exactly 3 cycles with `en`=1, `icnt`=3, state returns to 0 after each. A step while `op_halt`=1 → state=3 and `icnt` unchanged.
- btn_halt and btn_run pulses in the same cycle during RUN → state=0 (halt wins). Assert rst_n low mid-RUN → enables drop immediately, `icnt`=0.
- Preload `icnt` to near saturation (CNT_W=4), run 20 cycles → `icnt` stays at 15.
